// File: rtl/punc_datapath_gen.sv
// PUnC datapath: PC/IR/MDR/NZP, register file, ALU and a req/ack memory port with timeout.
// Register writes, PC/IR/NZP updates take effect on the next clock; the memory port takes 3+ cycles.
module punc_datapath_gen #(
  parameter int                DATA_W      = 16,
  parameter int                NREGS       = 8,
  parameter int                RF_AW       = $clog2(NREGS),
  parameter int                MEM_AW      = 16,
  parameter logic [DATA_W-1:0] PC_RESET    = '0,
  parameter int                MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_pc,
  input  logic [1:0]        pc_sel,
  input  logic              ld_ir,
  input  logic [RF_AW-1:0]  sr0_addr,
  input  logic [RF_AW-1:0]  sr1_addr,
  input  logic [RF_AW-1:0]  dr_addr,
  input  logic              rf_w_en,
  input  logic [1:0]        wb_sel,
  input  logic [1:0]        alu_op,
  input  logic              alu_b_sel,
  input  logic [1:0]        imm_sel,
  input  logic              ld_cc,
  input  logic              mem_start,
  input  logic              mem_we_in,
  input  logic [1:0]        maddr_sel,
  output logic [15:0]       ir,
  output logic [2:0]        nzp,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [RF_AW-1:0]  rf_debug_addr,
  output logic [DATA_W-1:0] rf_debug_data,
  output logic [DATA_W-1:0] pc_debug_data
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [2:0]        nzp_q;
  logic [DATA_W-1:0] rf_q [NREGS];

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              mem_cap;
  logic              mdr_ld;

  logic [DATA_W-1:0] sext5, sext6, sext9, sext11, imm_val;
  logic [DATA_W-1:0] rd0, rd1, alu_b, alu_res, wb_val, maddr_full;
  logic [2:0]        nzp_new;

  assign sext5  = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign sext6  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign sext9  = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
  assign sext11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

  always_comb begin
    imm_val = sext5;
    case (imm_sel)
      2'd0:    imm_val = sext5;
      2'd1:    imm_val = sext6;
      2'd2:    imm_val = sext9;
      default: imm_val = sext11;
    endcase
  end

  // Reads see the pre-write contents; a same-cycle write is visible next cycle.
  assign rd0           = rf_q[sr0_addr];
  assign rd1           = rf_q[sr1_addr];
  assign rf_debug_data = rf_q[rf_debug_addr];

  assign alu_b = alu_b_sel ? sext5 : rd1;

  always_comb begin
    alu_res = rd0 + alu_b;
    case (alu_op)
      2'd0:    alu_res = rd0 + alu_b;
      2'd1:    alu_res = rd0 & alu_b;
      2'd2:    alu_res = ~rd0;
      default: alu_res = rd0;
    endcase
  end

  always_comb begin
    wb_val = alu_res;
    case (wb_sel)
      2'd0:    wb_val = alu_res;
      2'd1:    wb_val = mdr_q;
      2'd2:    wb_val = pc_q;
      default: wb_val = pc_q + imm_val;
    endcase
  end

  always_comb begin
    if (wb_val[DATA_W-1])   nzp_new = 3'b100;
    else if (wb_val == '0)  nzp_new = 3'b010;
    else                    nzp_new = 3'b001;
  end

  always_comb begin
    pc_d = pc_q;
    if (ld_pc) begin
      case (pc_sel)
        2'd0:    pc_d = pc_q + DATA_W'(1);
        2'd1:    pc_d = pc_q + sext9;
        2'd2:    pc_d = rd0;
        default: pc_d = mdr_q;
      endcase
    end
  end

  always_comb begin
    maddr_full = pc_q;
    case (maddr_sel)
      2'd0:    maddr_full = pc_q;
      2'd1:    maddr_full = pc_q + imm_val;
      2'd2:    maddr_full = rd0 + imm_val;
      default: maddr_full = mdr_q;
    endcase
  end

  // Memory transaction FSM; the wait counter restarts on every new request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mem_cap = 1'b0;
    mdr_ld  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_start) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          mem_cap = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_d = S_DONE;
          mdr_ld  = ~we_q;
        end else if ((MEM_TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (mem_cap) begin
        addr_q  <= maddr_full[MEM_AW-1:0];
        wdata_q <= rd1;
        we_q    <= mem_we_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= PC_RESET;
      ir_q  <= '0;
      mdr_q <= '0;
      nzp_q <= 3'b010;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (ld_ir)   ir_q  <= mdr_q[15:0];
      if (mdr_ld)  mdr_q <= mem_rdata;
      if (ld_cc)   nzp_q <= nzp_new;
      if (rf_w_en) rf_q[dr_addr] <= wb_val;
    end
  end

  assign ir            = ir_q;
  assign nzp           = nzp_q;
  assign pc_debug_data = pc_q;
  assign mem_busy      = (state_q == S_BUSY);
  assign mem_req       = (state_q == S_BUSY);
  assign mem_done      = (state_q == S_DONE);
  assign mem_we        = (state_q == S_BUSY) & we_q;
  assign mem_err       = err_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: doc/punc_datapath_gen.md
Name: punc_datapath_gen

Overview:
Parametrised next-generation PUnC datapath. It owns PC, IR, MDR, the NZP condition codes, the register file and the ALU, and is driven cycle-by-cycle by the PUnC control FSM. Memory is external and is reached through a variable-latency req/ack port with timeout detection. Width, register count, address width and reset vector are all configurable.

Parameters:
DATA_W, 16, datapath/register width; must be >= 16, and IR fields are decoded from IR[15:0].
NREGS, 8, register-file entries; power of two, >= 2.
RF_AW, $clog2(NREGS), register address width.
MEM_AW, 16, memory address width; addresses are the low MEM_AW bits of the computed DATA_W value.
PC_RESET, 0, PC value after reset.
MEM_TIMEOUT, 255, max cycles waiting for mem_ack; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ld_pc  in  1  load PC
pc_sel  in  2  PC source: 0 PC+1, 1 PC+sext(IR[8:0]), 2 rf_rd0, 3 MDR
ld_ir  in  1  IR <= MDR
sr0_addr, sr1_addr, dr_addr  in  RF_AW each  register file read0 / read1 / write addresses
rf_w_en  in  1  register file write enable
wb_sel  in  2  writeback source: 0 ALU, 1 MDR, 2 PC, 3 PC+sext(imm)
alu_op  in  2  0 ADD, 1 AND, 2 NOT A, 3 PASS A
alu_b_sel  in  1  0 rf_rd1, 1 sext(IR[4:0])
imm_sel  in  2  sign-extend IR[4:0] / IR[5:0] / IR[8:0] / IR[10:0]
ld_cc  in  1  update NZP from the writeback value
mem_start  in  1  start a memory transaction
mem_we_in  in  1  transaction is a write (sampled with mem_start)
maddr_sel  in  2  address: 0 PC, 1 PC+sext(imm), 2 rf_rd0+sext(imm), 3 MDR
ir  out  16  IR[15:0], for decode
nzp  out  3  condition codes {N,Z,P}
mem_busy  out  1  transaction outstanding
mem_done  out  1  one-cycle completion pulse
mem_err  out  1  sticky timeout flag
mem_req  out  1  memory request
mem_we  out  1  memory write strobe
mem_addr  out  MEM_AW  memory address
mem_wdata  out  DATA_W  write data (rf_rd1)
mem_rdata  in  DATA_W  read data
mem_ack  in  1  memory acknowledge
rf_debug_addr  in  RF_AW  debug read address
rf_debug_data  out  DATA_W  debug read data
pc_debug_data  out  DATA_W  current PC

Behaviour:
- Reset (async, on assertion): PC=PC_RESET, IR=0, MDR=0, all registers 0, nzp=3'b010, FSM=IDLE. mem_req, mem_we, mem_busy, mem_done and mem_err are 0; mem_addr and mem_wdata are 0.
- Register file: three combinational reads (rd0, rd1, debug); one synchronous write on rising clk when rf_w_en=1. A read of the address being written in the same cycle returns the old value; the new value is visible next cycle. R0 is an ordinary register.
- Arithmetic: all results are DATA_W wide, and overflow wraps modulo 2^DATA_W. sext() extends from the field MSB to DATA_W. PC+1 wraps from all-ones to 0.
- NZP: when ld_cc=1, latch from the writeback value. N = MSB. Z = value==0. P = otherwise. Exactly one bit is set at all times.
- Simultaneous ld_pc and wb_sel=2: writeback uses the pre-update PC.
- Memory FSM states:
  - IDLE: mem_start=1 registers mem_addr, mem_wdata and mem_we, and goes to BUSY.
  - BUSY: mem_req=1 and mem_busy=1; all outputs are held stable.
  - DONE: mem_done=1 for one cycle, then IDLE.
- BUSY transitions:
  - mem_ack=1 -> DONE; on a read, MDR <= mem_rdata.
  - Timeout: if MEM_TIMEOUT>0 and the wait count reaches MEM_TIMEOUT with no ack -> IDLE, mem_err=1, MDR unchanged, no mem_done.
- Transaction rules:
  - Minimum transaction is 3 cycles: start, ack, done.
  - mem_start is ignored in BUSY and DONE.
  - mem_ack outside BUSY is ignored.
  - ld_ir and pc_sel=3 sample MDR as currently registered; the controller waits for mem_done.
- mem_err clears only on reset.
- Reset mid-transaction: mem_req drops immediately and the FSM goes to IDLE.

Test Plan:
- Reset with PC_RESET=16'h3000 -> pc_debug_data=3000, nzp=010, rf_debug_data=0 for all addresses, mem_req=0.
- Write R2=16'h7FFF, then ADD R3=R2+sext(IR[4:0]=5'b00001) with ld_cc -> R3=8000, nzp=100; AND R3 with 0 -> R3=0, nzp=010.
- Read at PC=3000 with ack after 4 cycles returning 16'h1234 -> mem_req high for 4 cycles, mem_done pulses once, MDR/IR=1234.
- Write R1=ABCD to address R0+sext(6'h3F) with R0=5 -> mem_addr=0004, mem_we=1, mem_wdata=ABCD; a second mem_start while busy is ignored.
- MEM_TIMEOUT=8, no ack -> after 8 wait cycles FSM is IDLE, mem_err=1 (sticky), mem_done never pulses.
- rf_w_en to R4 in the same cycle as a debug read of R4 -> old value that cycle, new value next cycle. Assert rst while BUSY -> mem_req=0 immediately.
